// File: rtl/noc_tx_arbiter.sv
// noc_tx_arbiter: round-robin arbiter/serializer sharing one NoC transmit port among NUM_SRC requesters.
// Define NOC_TX_ARB_SRC_STAMP_EN to stamp my_chip_id/my_x/my_y into each outgoing header's source fields.
package noc_tx_arbiter_pkg;
   localparam int MSG_SRC_CHIPID_W = 14;
   localparam int MSG_SRC_X_W      = 8;
   localparam int MSG_SRC_Y_W      = 8;

   typedef struct packed {
      logic [MSG_SRC_CHIPID_W-1:0] dst_chip_id;
      logic [7:0]                  dst_x_coord;
      logic [7:0]                  dst_y_coord;
      logic [3:0]                  fbits;
      logic [7:0]                  msg_len;
      logic [7:0]                  msg_type;
      logic [7:0]                  mshr_tag;
      logic [MSG_SRC_CHIPID_W-1:0] src_chip_id;
      logic [MSG_SRC_X_W-1:0]      src_x_coord;
      logic [MSG_SRC_Y_W-1:0]      src_y_coord;
      logic [423:0]                rsvd;
   } noc_hdr_flit;
endpackage

module noc_tx_arbiter
   import noc_tx_arbiter_pkg::*;
#(
   parameter int NUM_SRC    = 4,
   parameter int NOC_DATA_W = 512,
   parameter int SRC_IDX_W  = $clog2(NUM_SRC)
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic [NUM_SRC-1:0]                  src_hdr_val,
   input  logic [NUM_SRC-1:0][NOC_DATA_W-1:0]  src_hdr,
   output logic [NUM_SRC-1:0]                  src_hdr_rdy,
   input  logic [NUM_SRC-1:0]                  src_data_val,
   input  logic [NUM_SRC-1:0][NOC_DATA_W-1:0]  src_data,
   output logic [NUM_SRC-1:0]                  src_data_rdy,
   input  logic [MSG_SRC_CHIPID_W-1:0]         my_chip_id,
   input  logic [MSG_SRC_X_W-1:0]              my_x,
   input  logic [MSG_SRC_Y_W-1:0]              my_y,
   output logic                                noc_val,
   output logic [NOC_DATA_W-1:0]               noc_data,
   input  logic                                noc_rdy,
   output logic                                busy,
   output logic [SRC_IDX_W-1:0]                cur_src
);
   typedef enum logic {IDLE, DATA} state_t;

   state_t                state_q, state_d;
   logic [7:0]            rem_q, rem_d;
   logic [SRC_IDX_W-1:0]  rr_q, rr_d, cur_q, cur_d, win, idx;
   logic                  win_vld, load_ok, hdr_go, dat_go;
   logic                  out_vld_q, out_vld_d;
   logic [NOC_DATA_W-1:0] out_flit_q, out_flit_d;
   noc_hdr_flit           hdr;

   // Walk from the farthest offset down so the requester closest to rr_q wins.
   always_comb begin
      win_vld = 1'b0;
      win     = '0;
      idx     = '0;
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         idx = SRC_IDX_W'((int'(rr_q) + i) % NUM_SRC);
         if (src_hdr_val[idx]) begin
            win_vld = 1'b1;
            win     = idx;
         end
      end
   end

`ifdef NOC_TX_ARB_SRC_STAMP_EN
   always_comb begin
      hdr             = noc_hdr_flit'(src_hdr[win]);
      hdr.src_chip_id = my_chip_id;
      hdr.src_x_coord = my_x;
      hdr.src_y_coord = my_y;
   end
`else
   logic unused_my;
   assign unused_my = ^{my_chip_id, my_x, my_y};
   assign hdr = noc_hdr_flit'(src_hdr[win]);
`endif

   always_comb begin
      load_ok      = !out_vld_q || noc_rdy;
      hdr_go       = (state_q == IDLE) && win_vld && load_ok;
      dat_go       = (state_q == DATA) && src_data_val[cur_q] && load_ok;
      src_hdr_rdy  = hdr_go ? (NUM_SRC'(1) << win) : '0;
      src_data_rdy = dat_go ? (NUM_SRC'(1) << cur_q) : '0;
      state_d      = state_q;
      rem_d        = rem_q;
      rr_d         = rr_q;
      cur_d        = cur_q;
      if (hdr_go) begin
         cur_d   = win;
         rr_d    = (int'(win) == NUM_SRC - 1) ? '0 : win + 1'b1;
         rem_d   = hdr.msg_len;
         state_d = (hdr.msg_len == 8'd0) ? IDLE : DATA;
      end else if (dat_go) begin
         rem_d   = rem_q - 8'd1;
         state_d = (rem_q == 8'd1) ? IDLE : DATA;
      end
      out_vld_d  = (hdr_go || dat_go) ? 1'b1 : (noc_rdy ? 1'b0 : out_vld_q);
      out_flit_d = hdr_go ? NOC_DATA_W'(hdr) : (dat_go ? src_data[cur_q] : out_flit_q);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         rem_q      <= '0;
         rr_q       <= '0;
         cur_q      <= '0;
         out_vld_q  <= 1'b0;
         out_flit_q <= '0;
      end else begin
         state_q    <= state_d;
         rem_q      <= rem_d;
         rr_q       <= rr_d;
         cur_q      <= cur_d;
         out_vld_q  <= out_vld_d;
         out_flit_q <= out_flit_d;
      end
   end

   assign noc_val  = out_vld_q;
   assign noc_data = out_flit_q;
   assign busy     = (state_q == DATA) || out_vld_q;
   assign cur_src  = cur_q;
endmodule

// File: doc/noc_tx_arbiter.md
# noc_tx_arbiter

Round-robin arbiter and serializer that shares one NoC transmit port among `NUM_SRC` requesters. Each requester offers a complete `noc_hdr_flit` header followed by `msg_len` payload flits. The arbiter grants one requester at a time and locks the grant for the whole packet. It drives header then payload onto the NoC through a single registered output stage. It sits between the TCP engine's message producers and the tile's outbound NoC router port.

## Interface
Parameters:
- `NUM_SRC`, 4, number of requesters (2..8)
- `NOC_DATA_W`, 512, NoC flit width; must equal `$bits(noc_hdr_flit)`
- `SRC_IDX_W`, `$clog2(NUM_SRC)`, grant index width

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  clock
- `rst_n`  in  1  async active-low reset
- `src_hdr_val`  in  NUM_SRC  per-requester header valid
- `src_hdr`  in  NUM_SRC×NOC_DATA_W  per-requester header, `noc_hdr_flit` layout
- `src_hdr_rdy`  out  NUM_SRC  header accepted (one-hot or zero)
- `src_data_val`  in  NUM_SRC  per-requester payload valid
- `src_data`  in  NUM_SRC×NOC_DATA_W  per-requester payload flit
- `src_data_rdy`  out  NUM_SRC  payload accepted (one-hot or zero)
- `my_chip_id`, `my_x`, `my_y`  in  MSG_SRC_CHIPID/X/Y widths  local tile coordinates
- `noc_val`  out  1  output flit valid
- `noc_data`  out  NOC_DATA_W  output flit
- `noc_rdy`  in  1  router ready
- `busy`  out  1  packet in progress (state DATA or output reg full)
- `cur_src`  out  SRC_IDX_W  current/last granted requester

## Operation
- Output stage: one register (`out_vld`, `out_flit`). `load_ok = !out_vld || noc_rdy`. The register loads when `load_ok` and a transfer is accepted. Otherwise it clears on `noc_rdy` or holds.
- FSM:
  - IDLE: round-robin pick among `src_hdr_val`, starting at `rr_ptr`. If a winner exists and `load_ok`, assert `src_hdr_rdy[win]`, load the header, set `cur_src=win` and `rr_ptr=win+1` (mod NUM_SRC).
    - If `msg_len==0`, stay in IDLE.
    - Otherwise go to DATA with `rem=msg_len`.
  - DATA: only `cur_src` is eligible. When `src_data_val[cur_src] && load_ok`, assert `src_data_rdy[cur_src]`, load the flit and decrement `rem`. When `rem==1` on a transfer, return to IDLE.
- `src_hdr_rdy` is 0 in DATA. `src_data_rdy` is 0 in IDLE. Payload valid from non-granted requesters is ignored.
- `msg_len` is 8 bits, so each packet carries 0..255 payload flits. `rem` is 8 bits and never wraps.
- Requesters hold `val` and data stable until `rdy`; withdrawal is not supported.

## Timing
- Reset values: `noc_val=0`, `noc_data=0`, all `rdy=0`, `busy=0`, `cur_src=0`, `rr_ptr=0`, state IDLE, `rem=0`.
- Latency: 1 cycle from an accepted src transfer to `noc_val`.
- Throughput: 1 flit/cycle under continuous `noc_rdy`, including back-to-back packets. A 0-length packet can be followed by the next header the next cycle.
- Backpressure: with `noc_rdy=0` and the output full, all `rdy` are 0 and the output holds.
- Reset mid-packet: the packet is dropped and the output register is cleared. A partial packet may already be on the NoC; upstream must also be reset.
- `src_hdr_rdy`/`src_data_rdy` are combinational from `val`, state and `noc_rdy`. There is no combinational path from `noc_rdy` to `noc_val`.

## Configuration
- `NOC_TX_ARB_SRC_STAMP_EN` defined: on header load, the `src_chip_id`, `src_x_coord` and `src_y_coord` fields are overwritten with `my_chip_id`/`my_x`/`my_y`. All other fields pass through unchanged.
- Undefined: the header passes through bit-exact and the `my_*` ports are unused.

## Test plan
- Single src0 header, `msg_len=3`, payload A,B,C, `noc_rdy=1` -> `noc_val` high for 4 consecutive cycles starting 1 cycle after the header handshake, flits H,A,B,C; `busy` falls after C.
- src1 and src2 both request with `rr_ptr=0` and `msg_len=0` -> src1 is granted first, then src2 the next cycle; `cur_src` is 1 then 2; two back-to-back header flits.
- src0 mid-packet (`rem=2`) while src3 asserts `src_hdr_val` and `src_data_val` -> src3 is not granted until src0's last payload flit; no src3 payload reaches the NoC early.
- `noc_rdy` low for 5 cycles mid-packet -> `noc_data` stable, all `rdy=0`; on release the flit stream resumes with no loss or duplication.
- `rst_n` pulsed low during DATA with `rem=4` -> next cycle `noc_val=0`, state IDLE, `rr_ptr=0`; a fresh header is accepted after reset.
- With `NOC_TX_ARB_SRC_STAMP_EN` defined and `my_x=3`, `my_y=5`, header `src_x=0` -> emitted header has `src_x_coord=3`, `src_y_coord=5`, other fields unchanged. With the macro undefined, the header is bit-exact.
